// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage sitting between the PC and decode.
// Issues instruction reads at the current PC, writes returned words into the
// IF/ID register, parks one word in a skid buffer while decode stalls,
// squashes everything on flush and freezes permanently after a halt.
module fetch_stage #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      imem_addr,
  input  logic [31:0]      rtn_addr,
  output logic             pc_advance,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             ihit,
  input  logic [31:0]      iload,
  input  logic             stall,
  input  logic             flush,
  input  logic             halt,
  output logic             ifid_valid,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_npc,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic             ifid_valid_reg;
  logic [31:0]      ifid_instr_reg;
  logic [31:0]      ifid_pc_reg;
  logic [31:0]      ifid_npc_reg;
  logic [CNT_W-1:0] fetch_count_reg;
  logic [31:0]      skid_instr_reg;
  logic [31:0]      skid_pc_reg;
  logic [31:0]      skid_npc_reg;

  // A read is only outstanding in FETCH; the PC moves exactly when the
  // returned word is taken (into IF/ID or the skid). A flush drops the word
  // and leaves PC control free to redirect.
  assign iREN       = (state_reg == FETCH);
  assign iaddr      = imem_addr;
  assign pc_advance = (state_reg == FETCH) && ihit && !flush;

  assign ifid_valid  = ifid_valid_reg;
  assign ifid_instr  = ifid_instr_reg;
  assign ifid_pc     = ifid_pc_reg;
  assign ifid_npc    = ifid_npc_reg;
  assign fetch_count = fetch_count_reg;

  // State machine, IF/ID register, skid buffer and delivered-instruction counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg       <= FETCH;
      ifid_valid_reg  <= 1'b0;
      ifid_instr_reg  <= '0;
      ifid_pc_reg     <= '0;
      ifid_npc_reg    <= '0;
      fetch_count_reg <= '0;
      skid_instr_reg  <= '0;
      skid_pc_reg     <= '0;
      skid_npc_reg    <= '0;
    end else if (state_reg == HALTED) begin
      // Halted is terminal: nothing but reset leaves it, flush included.
      state_reg <= HALTED;
    end else if (flush) begin
      // Wrong-path squash; the IF/ID payload fields are left stale on purpose.
      ifid_valid_reg <= 1'b0;
      skid_instr_reg <= '0;
      skid_pc_reg    <= '0;
      skid_npc_reg   <= '0;
      state_reg      <= FETCH;
    end else begin
      case (state_reg)
        FETCH: begin
          if (ihit) begin
            if (!ifid_valid_reg || !stall) begin
              // An empty IF/ID is always writable, even under stall.
              ifid_valid_reg  <= 1'b1;
              ifid_instr_reg  <= iload;
              ifid_pc_reg     <= imem_addr;
              ifid_npc_reg    <= rtn_addr;
              fetch_count_reg <= fetch_count_reg + CNT_ONE;
            end else begin
              skid_instr_reg <= iload;
              skid_pc_reg    <= imem_addr;
              skid_npc_reg   <= rtn_addr;
              state_reg      <= HOLD;
            end
          end else if (!stall) begin
            // Decode consumed the entry and nothing arrived: insert a bubble.
            ifid_valid_reg <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_valid_reg  <= 1'b1;
            ifid_instr_reg  <= skid_instr_reg;
            ifid_pc_reg     <= skid_pc_reg;
            ifid_npc_reg    <= skid_npc_reg;
            fetch_count_reg <= fetch_count_reg + CNT_ONE;
            state_reg       <= FETCH;
          end
        end
        default: begin
          state_reg <= FETCH;
        end
      endcase
      // The halt takes effect after this cycle's normal work is done.
      if (halt) begin
        state_reg <= HALTED;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a
// behavioural model of the fetch rules, plus literal spot checks.
module tb_fetch_stage;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [31:0]      imem_addr, rtn_addr, iaddr, iload;
  logic             pc_advance, iREN, ihit, stall, flush, halt;
  logic             ifid_valid;
  logic [31:0]      ifid_instr, ifid_pc, ifid_npc;
  logic [CNT_W-1:0] fetch_count;

  fetch_stage #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .imem_addr(imem_addr), .rtn_addr(rtn_addr),
    .pc_advance(pc_advance), .iREN(iREN), .iaddr(iaddr), .ihit(ihit),
    .iload(iload), .stall(stall), .flush(flush), .halt(halt),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_npc(ifid_npc), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Behavioural model: the IF/ID contents, a parked word, and two flags.
  logic             m_valid;
  logic [31:0]      m_instr, m_pc, m_npc;
  logic [CNT_W-1:0] m_count;
  logic             m_parked, m_halted;
  logic [31:0]      p_instr, p_pc, p_npc;

  logic pa, ir, ep;
  logic [31:0] rp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_instr = 0; m_pc = 0; m_npc = 0; m_count = 0;
    m_parked = 0; m_halted = 0; p_instr = 0; p_pc = 0; p_npc = 0;
  endtask

  // One clock cycle: drive inputs just after an edge, compare everything
  // against the model, advance the model, return just after the next edge.
  task automatic cycle(input logic [31:0] addr, input logic hit, input logic [31:0] load,
                       input logic st, input logic fl, input logic hl,
                       output logic pa_act, output logic iren_act, output logic exp_pa);
    logic fetching;
    imem_addr = addr; rtn_addr = addr + 32'd4; ihit = hit; iload = load;
    stall = st; flush = fl; halt = hl;
    #1;
    fetching = !m_halted && !m_parked;
    exp_pa = fetching && hit && !fl;
    chk("pc_advance", pc_advance, exp_pa);
    chk("iREN", iREN, fetching);
    chk("iaddr", iaddr, addr);
    chk("ifid_valid", ifid_valid, m_valid);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc", ifid_pc, m_pc);
    chk("ifid_npc", ifid_npc, m_npc);
    chk("fetch_count", fetch_count, m_count);
    pa_act = pc_advance;
    iren_act = iREN;
    if (m_halted) begin
      // frozen forever
    end else if (fl) begin
      m_valid = 0; m_parked = 0;
    end else begin
      if (m_parked) begin
        if (!st) begin
          m_valid = 1; m_instr = p_instr; m_pc = p_pc; m_npc = p_npc;
          m_count = m_count + 1'b1; m_parked = 0;
        end
      end else if (hit) begin
        if (!m_valid || !st) begin
          m_valid = 1; m_instr = load; m_pc = addr; m_npc = addr + 32'd4;
          m_count = m_count + 1'b1;
        end else begin
          p_instr = load; p_pc = addr; p_npc = addr + 32'd4; m_parked = 1;
        end
      end else if (!st) begin
        m_valid = 0;
      end
      if (hl) m_halted = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #2;
    nRST = 0;
    #1;
    chk("rst_valid", ifid_valid, 0);
    chk("rst_instr", ifid_instr, 0);
    chk("rst_pc", ifid_pc, 0);
    chk("rst_npc", ifid_npc, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_iREN", iREN, 1);
    model_reset();
    ihit = 0; stall = 0; flush = 0; halt = 0; iload = 0;
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 0; imem_addr = 0; rtn_addr = 4; ihit = 0; iload = 0;
    stall = 0; flush = 0; halt = 0;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // Zero-wait back-to-back fetch.
    cycle(32'h0, 1, 32'h11110000, 0, 0, 0, pa, ir, ep); chk("zw_pa0", pa, 1);
    cycle(32'h4, 1, 32'h11110004, 0, 0, 0, pa, ir, ep); chk("zw_pa1", pa, 1);
    cycle(32'h8, 1, 32'h11110008, 0, 0, 0, pa, ir, ep); chk("zw_pa2", pa, 1);
    chk("zw_pc", ifid_pc, 32'h8); chk("zw_npc", ifid_npc, 32'hC);
    chk("zw_count", fetch_count, 3); chk("zw_valid", ifid_valid, 1);

    // Three wait cycles then a hit at 0x10.
    repeat (3) begin
      cycle(32'h10, 0, 32'h0, 0, 0, 0, pa, ir, ep); chk("wait_pa", pa, 0);
    end
    cycle(32'h10, 1, 32'hDEAD0010, 0, 0, 0, pa, ir, ep); chk("hit_pa", pa, 1);
    chk("hit_pc", ifid_pc, 32'h10); chk("hit_instr", ifid_instr, 32'hDEAD0010);
    chk("hit_count", fetch_count, 4);

    // Skid under stall and release.
    cycle(32'h20, 1, 32'hA0000020, 0, 0, 0, pa, ir, ep);
    cycle(32'h24, 1, 32'hA0000024, 1, 0, 0, pa, ir, ep); chk("skid_pa", pa, 1);
    chk("skid_pc_hold", ifid_pc, 32'h20); chk("skid_count", fetch_count, 5);
    cycle(32'h28, 0, 32'h0, 1, 0, 0, pa, ir, ep); chk("hold_iren", ir, 0);
    cycle(32'h28, 0, 32'h0, 0, 0, 0, pa, ir, ep); chk("rel_iren", ir, 0);
    chk("rel_pc", ifid_pc, 32'h24); chk("rel_instr", ifid_instr, 32'hA0000024);
    chk("rel_count", fetch_count, 6);

    // Flush while holding 0x34 in the skid.
    cycle(32'h30, 1, 32'hA0000030, 0, 0, 0, pa, ir, ep);
    cycle(32'h34, 1, 32'hA0000034, 1, 0, 0, pa, ir, ep);
    cycle(32'h38, 0, 32'h0, 1, 1, 0, pa, ir, ep);
    chk("fl_valid", ifid_valid, 0); chk("fl_count", fetch_count, 7);
    cycle(32'h38, 1, 32'hB0000038, 0, 0, 0, pa, ir, ep); chk("fl_iren", ir, 1);
    chk("fl_pc", ifid_pc, 32'h38); chk("fl_count2", fetch_count, 8);

    // Halt accepted together with a hit, then frozen.
    cycle(32'h40, 1, 32'hC0000040, 0, 0, 1, pa, ir, ep); chk("halt_pa", pa, 1);
    chk("halt_pc", ifid_pc, 32'h40); chk("halt_count", fetch_count, 9);
    repeat (2) begin
      cycle(32'h44, 1, 32'hC0000044, 0, 0, 0, pa, ir, ep);
      chk("halted_iren", ir, 0); chk("halted_pa", pa, 0);
    end
    chk("halted_pc", ifid_pc, 32'h40); chk("halted_count", fetch_count, 9);

    // Halt together with flush is ignored.
    do_reset();
    cycle(32'h0, 1, 32'h5, 0, 1, 1, pa, ir, ep); chk("hf_pa", pa, 0);
    cycle(32'h0, 1, 32'h6, 0, 0, 0, pa, ir, ep);
    chk("hf_iren", ir, 1); chk("hf_pa2", pa, 1); chk("hf_count", fetch_count, 1);

    // Counter wrap at 4 bits.
    for (int i = 0; i < 14; i++) cycle(32'h4 + 32'(i) * 4, 1, $urandom, 0, 0, 0, pa, ir, ep);
    chk("wrap_ones", fetch_count, 15);
    cycle(32'h100, 1, 32'h77, 0, 0, 0, pa, ir, ep);
    chk("wrap_zero", fetch_count, 0);

    // Reset mid-wait and mid-HOLD.
    cycle(32'h100, 0, 32'h0, 0, 0, 0, pa, ir, ep);
    do_reset();
    cycle(32'h200, 1, 32'h200, 0, 0, 0, pa, ir, ep);
    cycle(32'h204, 1, 32'h204, 1, 0, 0, pa, ir, ep);
    do_reset();
    cycle(32'h300, 1, 32'h300, 0, 0, 0, pa, ir, ep);
    chk("post_hold_rst_pc", ifid_pc, 32'h300); chk("post_hold_rst_count", fetch_count, 1);

    // Randomized episodes driven by a bench-side PC.
    for (int e = 0; e < 6; e++) begin
      do_reset();
      rp = 32'($urandom_range(0, 1023)) << 2;
      for (int c = 0; c < 200; c++) begin
        logic h, s, f, hl;
        h  = ($urandom_range(0, 99) < 65);
        s  = ($urandom_range(0, 99) < 35);
        f  = ($urandom_range(0, 99) < 5);
        hl = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
        end
        cycle(rp, h, $urandom, s, f, hl, pa, ir, ep);
        if (f) rp = 32'($urandom_range(0, 1023)) << 2;
        else if (ep) rp = rp + 32'd4;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly downstream of the program counter. Takes the current fetch address and its return address from the PC, issues instruction-memory reads, and holds each returned word in the IF/ID pipeline register. Absorbs one instruction during a decode stall in a one-entry skid buffer, discards wrong-path fetches on flush, and tells PC control when it may advance.

## Interface
Parameters:
- CNT_W, 32, width of the delivered-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- imem_addr  in  32  current PC value from the PC block
- rtn_addr  in  32  current PC + 4 from the PC block
- pc_advance  out  1  PC may take next_pc this cycle; when 0, PC control selects HALT (hold)
- iREN  out  1  instruction read request to the memory/cache side
- iaddr  out  32  instruction read address
- ihit  in  1  read data valid this cycle
- iload  in  32  instruction word, valid when ihit=1
- stall  in  1  decode stage cannot accept a new IF/ID entry
- flush  in  1  redirect resolved downstream; squash everything in fetch
- halt  in  1  halt opcode confirmed downstream; stop fetching
- ifid_valid  out  1  IF/ID entry holds a live instruction
- ifid_instr  out  32  IF/ID instruction
- ifid_pc  out  32  address of ifid_instr
- ifid_npc  out  32  ifid_pc + 4
- fetch_count  out  CNT_W  instructions written into IF/ID since reset (wraps)

## Operation
- States: FETCH, HOLD, HALTED. Reset enters FETCH.
- FETCH: iREN=1, iaddr=imem_addr (combinational). Requires iaddr stable while waiting; the PC holds because pc_advance=0 until ihit.
  - ihit & (!ifid_valid | !stall): IF/ID <= {1, iload, imem_addr, rtn_addr}; pc_advance=1; fetch_count++.
  - ihit & ifid_valid & stall: skid <= {iload, imem_addr, rtn_addr}; pc_advance=1; go HOLD.
  - !ihit: pc_advance=0; IF/ID holds, except when !stall, ifid_valid clears to 0 (bubble).
- HOLD: iREN=0, pc_advance=0. When stall=0: IF/ID <= skid, ifid_valid=1, fetch_count++, go FETCH. Otherwise hold.
- HALTED: iREN=0, pc_advance=0; IF/ID and counter frozen; exit only via reset.
- flush (highest priority below reset): ifid_valid <= 0, skid discarded, state <= FETCH, pc_advance=0, any ihit data that cycle dropped, no count increment. ifid_instr/pc/npc keep their stale values.
- halt & !flush: state <= HALTED at the next edge. In-cycle ihit is still accepted per FETCH rules. halt asserted together with flush is ignored.
- stall with ifid_valid=0 never blocks: an empty IF/ID is always writable.
- fetch_count wraps modulo 2^CNT_W.

## Timing
- Reset (async assert): ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_npc=0, fetch_count=0, skid cleared, state=FETCH. After deassertion, iREN=1 and iaddr=imem_addr in the same cycle.
- pc_advance, iREN, and iaddr are combinational from the state and inputs. All other outputs are registered.
- Latency: ihit in cycle N gives IF/ID valid after edge N; the PC updates at that same edge.
- Zero-wait memory (ihit held at 1, no stall): one instruction per cycle, back to back.
- Skid release: stall drops in cycle M, so the skid entry appears in IF/ID after edge M. The next request issues in cycle M+1.
- Reset mid-HOLD or mid-wait: all state is cleared immediately. No partial entry survives.

## Test plan
- Reset, ihit tied to 1, imem_addr 0x0/0x4/0x8 over cycles 1-3 -> ifid_pc 0x0, 0x4, 0x8 on successive edges; ifid_npc = pc+4; fetch_count=3; pc_advance=1 each cycle.
- ihit delayed 3 cycles for addr 0x10 -> pc_advance=0 and iaddr=0x10 for 3 cycles; IF/ID gets iload with ifid_pc=0x10 on the hit edge.
- IF/ID valid with 0x20, stall=1, ihit for 0x24 -> state HOLD, IF/ID still 0x20, iREN=0; stall drops -> IF/ID=0x24 next edge; fetch_count +1 only then.
- flush during HOLD with skid holding 0x24 -> ifid_valid=0, skid discarded, state FETCH; 0x24 never appears; count unchanged.
- halt with ihit for 0x40 -> 0x40 enters IF/ID; then iREN=0 and pc_advance=0 permanently; halt+flush together -> halt ignored, fetch continues.
- Reset asserted mid-wait and mid-HOLD -> all outputs at reset values asynchronously; fetch_count wraps from all-ones to 0 with CNT_W=4.
